// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide HI/LO unit: opcodes,
// controller states and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } stateT;

  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             quotBit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // remIn < divisor always holds, so a borrow out of bit WIDTH means "does not fit".
  always_comb begin
    partial = {remIn, dividendBit};
    diff    = partial - {1'b0, divisor};
    quotBit = ~diff[WIDTH];
    remOut  = quotBit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply / divide / accumulate unit owning the HI/LO pair.
// Define MULDIV_DIV_EN to build the restoring divider and divide-by-zero path.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  stateT              state;
  logic [2:0]         opReg;
  logic [CW-1:0]      iterCnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               negRes;

  logic               signedOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] prodSigned;
  logic [2*WIDTH-1:0] hiLoNext;

`ifdef MULDIV_DIV_EN
  logic             negRem;
  logic [WIDTH-1:0] stepRem;
  logic             stepQuot;

  muldiv_div_step #(.WIDTH(WIDTH)) uDivStep (
    .remIn      (acc[2*WIDTH-1:WIDTH]),
    .dividendBit(acc[WIDTH-1]),
    .divisor    (mcand),
    .remOut     (stepRem),
    .quotBit    (stepQuot)
  );
`endif

  always_comb begin
    signedOp = isSignedOp(Op);
    magA     = (signedOp && A[WIDTH-1]) ? -A : A;
    magB     = (signedOp && B[WIDTH-1]) ? -B : B;
  end

  // Multiply: acc = {partial product, multiplier}, add-then-shift-right.
  // Divide:   acc = {remainder, dividend/quotient}, shift-left with quotient bit in.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    accNext = {addSum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (isDivOp(opReg)) accNext = {stepRem, acc[WIDTH-2:0], stepQuot};
`endif
  end

  always_comb begin
    prodSigned = negRes ? -acc : acc;
    hiLoNext   = prodSigned;
    case (opReg)
      OP_MADD: hiLoNext = {Hi, Lo} + prodSigned;
      OP_MSUB: hiLoNext = {Hi, Lo} - prodSigned;
      default: ;
    endcase
`ifdef MULDIV_DIV_EN
    if (isDivOp(opReg))
      hiLoNext = {(negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]),
                  (negRes ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0])};
`endif
  end

  // NOTE: the datapath registers are few and reset with the rest, so a
  // mid-operation reset leaves nothing stale behind.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      opReg   <= OP_MULT;
      iterCnt <= '0;
      mcand   <= '0;
      acc     <= '0;
      negRes  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
`ifdef MULDIV_DIV_EN
      negRem    <= 1'b0;
      DivByZero <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      Done <= 1'b0;
`ifdef MULDIV_DIV_EN
      DivByZero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            opReg   <= Op;
            iterCnt <= '0;
            negRes  <= signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            negRem  <= signedOp && A[WIDTH-1];
`endif
            case (Op)
              OP_MTHI: begin
                Hi   <= A;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                Lo   <= A;
                Done <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (B == '0) begin
                  Hi        <= A;
                  Lo        <= '1;
                  Done      <= 1'b1;
                  DivByZero <= 1'b1;
                end else begin
                  mcand <= magB;
                  acc   <= {{WIDTH{1'b0}}, magA};
                  state <= RUN;
                  Busy  <= 1'b1;
                end
`else
                Done <= 1'b1;
`endif
              end
              default: begin
                mcand <= magA;
                acc   <= {{WIDTH{1'b0}}, magB};
                state <= RUN;
                Busy  <= 1'b1;
              end
            endcase
          end
        end
        RUN: begin
          if (Flush) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            acc     <= accNext;
            iterCnt <= iterCnt + 1'b1;
            if (iterCnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!Flush) begin
            {Hi, Lo} <= hiLoNext;
            Done     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MULDIV_DIV_EN
  assign DivByZero = 1'b0;
`endif

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Multi-cycle multiply/divide unit owning the architectural HI/LO pair. It replaces the single-cycle HI/LO update path in the EX stage with a parametrised iterative engine, a start/busy/done handshake, a pipeline flush input and multiply-accumulate support. EX issues an operation and stalls on `Busy`. `mfhi`/`mflo` read `Hi`/`Lo` directly.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4 and even.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-low reset.
- `Start`  in  1  issue request; sampled on the rising edge and accepted only when `Busy`=0 and `Flush`=0.
- `Op`  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- `A`, `B`  in  WIDTH  operands: rs and rt, or the dividend and divisor.
- `Flush`  in  1  abort any in-flight operation.
- `Busy`  out  1  high while an iterative operation is in flight.
- `Done`  out  1  one-cycle pulse in the cycle after `Hi`/`Lo` are written.
- `DivByZero`  out  1  pulses together with `Done` when a divide had `B`=0.
- `Hi`, `Lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- Reset values: `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, `DivByZero`=0. The state machine resets to IDLE.
- States:
  - IDLE: waits for an accepted `Start`.
  - RUN: performs WIDTH iterations.
  - FIX: applies sign correction and accumulation, writes HI/LO, then returns to IDLE.
- `Busy` is 1 whenever the state is not IDLE.
- At acceptance, operands are latched. For signed operations the magnitudes are latched and the result signs are recorded.
- MULT/MULTU: shift-add, one bit per cycle. The 2·WIDTH-bit product is split with the upper half to Hi and the lower half to Lo.
- MADD/MSUB: the signed product is added to or subtracted from {Hi,Lo} in FIX, modulo 2^(2·WIDTH).
- DIV/DIVU: restoring division, one quotient bit per cycle.
  - Quotient goes to Lo, remainder goes to Hi.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - MIN/−1 produces Lo=MIN, Hi=0.
- Divide with `B`=0:
  - No RUN state is entered.
  - `Hi`=`A` and `Lo`=all ones are written on the accept edge.
  - `Done` and `DivByZero` pulse in the next cycle.
- MTHI/MTLO: `Hi` (or `Lo`) = `A` on the accept edge; the other register is unchanged. `Busy` never rises, and `Done` pulses in the next cycle.
- `Start` while `Busy`=1 is ignored; no queueing.
- `Flush`=1 in RUN or FIX:
  - Returns to IDLE on that edge.
  - `Hi`/`Lo` keep their pre-operation values and no `Done` pulse is produced.
- `Flush` and `Start` in the same cycle: `Flush` wins and the `Start` is dropped.
- `Flush` in IDLE has no effect.
- `Rst` asserted mid-operation: all state is cleared immediately and asynchronously, with no partial HI/LO write.

## Timing
- The accept edge is E0. RUN occupies E1..E(WIDTH), FIX writes `Hi`/`Lo` at E(WIDTH+1), and `Done` is high for the cycle after E(WIDTH+1).
- `Busy` is high from after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles; it is low in the same cycle `Done` is high.
- Back-to-back issue: a new `Start` can be accepted in the `Done` cycle.
- MTHI/MTLO and divide-by-zero: write at E0, `Done` after E0, with 1-cycle latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MULDIV_DIV_EN` defined: the restoring divider and divide-by-zero handling are present, as described above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath is absent.
  - DIV/DIVU are accepted as single-cycle no-ops: `Hi`/`Lo` are unchanged, `Done` pulses after E0 and `Busy` stays 0.
  - `DivByZero` is tied to 0.
  - Multiply, accumulate and move operations are unaffected.

## Structure
- Package `muldiv_pkg` contains:
  - the `Op` encodings as named constants;
  - the state enum (IDLE, RUN, FIX);
  - the helper for the iteration-counter width, $clog2(WIDTH+1).
- One sub-module, `muldiv_div_step`: a combinational single restoring-division iteration taking the partial remainder, dividend bit and divisor, and returning the new remainder and quotient bit. It is instantiated only under `MULDIV_DIV_EN`.

## Test plan
All scenarios use WIDTH=32.
- MULT A=0xFFFFFFFD, B=7 → after E33: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; `Done` is a single 1-cycle pulse; `Busy` is high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. Then MADD with Hi=0, Lo=0xFFFFFFFF, A=B=1 → Hi=1, Lo=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU A=7, B=0 → `Done` and `DivByZero` after 1 cycle, Hi=7, Lo=0xFFFFFFFF.
- Issue MULT, pulse `Start` again at cycle 5 (ignored), then `Flush` at cycle 10 → `Busy` low the next cycle, no `Done`, Hi/Lo unchanged.
- MTLO A=0x12345678 → Lo updated at E0, `Done` the next cycle, `Busy` never high, Hi unchanged.
- Assert `Rst` low at cycle 20 of a DIV → Hi, Lo, `Busy`, `Done` and `DivByZero` are 0 without waiting for a clock edge. After release, a new MULT completes normally.
